// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the requester handshake, response and memory-side signals of the
// data-memory port arbiter. The arbiter takes the slave view; whatever drives
// the requests and models the memory takes the master view.
interface dmem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic              req_we0;
    logic              req_we1;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  req_valid, req_we0, req_we1, req_addr0, req_addr1,
               req_wdata0, req_wdata1, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata,
               mem_wr, mem_rd, mem_addr, mem_wr_data
    );

    modport master (
        output req_valid, req_we0, req_we1, req_addr0, req_addr1,
               req_wdata0, req_wdata1, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata,
               mem_wr, mem_rd, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single data-memory port. Port 0 (core) has
// priority; port 1 (debug/loader) is guaranteed a grant after STARVE_LIM
// consecutive port-0 wins while it waits. One access in flight at a time:
// accept (IDLE) -> memory strobe (ACCESS) -> response pulse (RESP).
module dmem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [1:0]        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        grant;
    logic              accept;

    // Pick at most one winner while idle; nothing is offered while reset is held.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && reset) begin
            if (bus.req_valid[1] && (!bus.req_valid[0] || starve_q == LIM)) begin
                grant = 2'b10;
            end else if (bus.req_valid[0]) begin
                grant = 2'b01;
            end
        end
    end

    // A grant is only ever given to a valid port, so any grant is a transfer.
    assign accept = |grant;

    // Sequence the single in-flight access and track how long port 1 has waited.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    id_d    = grant[1];
                    we_d    = grant[1] ? bus.req_we1    : bus.req_we0;
                    addr_d  = grant[1] ? bus.req_addr1  : bus.req_addr0;
                    wdata_d = grant[1] ? bus.req_wdata1 : bus.req_wdata0;
                    if (grant[0] && bus.req_valid[1]) begin
                        starve_d = (starve_q == LIM) ? starve_q : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // The latched address/data only change on an accept, so they sit on the
    // memory bus during ACCESS and hold their last value otherwise.
    assign bus.req_ready   = grant;
    assign bus.mem_rd      = (state_q == ACCESS) && !we_q;
    assign bus.mem_wr      = (state_q == ACCESS) && we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdata_q;
    assign bus.rsp_valid   = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_rdata   = (state_q == RESP && !we_q) ? bus.mem_rd_data : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a table of single transactions,
// hand-written reset/starvation/contention sequences, then random traffic
// compared every cycle against a transaction-level reference model.
module tb_dmem_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int LIM    = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    dmem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIM(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic        we0;
        logic [8:0]  addr0;
        logic [31:0] wdata0;
        logic        we1;
        logic [8:0]  addr1;
        logic [31:0] wdata1;
        logic [31:0] rdData;
        logic [1:0]  expReady;
        logic        expRd;
        logic        expWr;
        logic [8:0]  expAddr;
        logic [31:0] expWdata;
        logic [1:0]  expRsp;
        logic [31:0] expRdata;
    } vec_t;

    // Reference model state: age is the number of cycles since the access in
    // flight was accepted (-1 when none); port0Streak counts port-0 wins in a
    // row taken while port 1 was also asking.
    int          age;
    int          port0Streak;
    logic        txPort;
    logic        txWe;
    logic [8:0]  lastAddr;
    logic [31:0] lastData;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        age         = -1;
        port0Streak = 0;
        txPort      = 1'b0;
        txWe        = 1'b0;
        lastAddr    = '0;
        lastData    = '0;
    endtask

    function automatic logic [1:0] modelWinner(input logic [1:0] v);
        if (age >= 0 || reset == 1'b0) return 2'b00;
        if (v == 2'b11) return (port0Streak >= LIM) ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic checkAgainstModel();
        logic [1:0]  expRsp;
        logic [31:0] expRdata;
        expRsp   = (age == 2) ? (txPort ? 2'b10 : 2'b01) : 2'b00;
        expRdata = (age == 2 && !txWe) ? bus.mem_rd_data : 32'd0;
        checkOutput("rnd_req_ready",   bus.req_ready,   modelWinner(bus.req_valid));
        checkOutput("rnd_mem_rd",      bus.mem_rd,      (age == 1) && !txWe);
        checkOutput("rnd_mem_wr",      bus.mem_wr,      (age == 1) && txWe);
        checkOutput("rnd_mem_addr",    bus.mem_addr,    lastAddr);
        checkOutput("rnd_mem_wr_data", bus.mem_wr_data, lastData);
        checkOutput("rnd_rsp_valid",   bus.rsp_valid,   expRsp);
        checkOutput("rnd_rsp_rdata",   bus.rsp_rdata,   expRdata);
    endtask

    task automatic modelClock(output logic [1:0] granted);
        granted = modelWinner(bus.req_valid);
        if (age == 2) begin
            age = -1;
        end else if (age >= 0) begin
            age++;
        end else if (granted != 2'b00) begin
            txPort   = granted[1];
            txWe     = granted[1] ? bus.req_we1    : bus.req_we0;
            lastAddr = granted[1] ? bus.req_addr1  : bus.req_addr0;
            lastData = granted[1] ? bus.req_wdata1 : bus.req_wdata0;
            age      = 1;
            if (granted[0] && bus.req_valid[1])
                port0Streak = (port0Streak < LIM) ? port0Streak + 1 : LIM;
            else
                port0Streak = 0;
        end
    endtask

    task automatic idleInputs();
        bus.req_valid   = 2'b00;
        bus.req_we0     = 1'b0;
        bus.req_we1     = 1'b0;
        bus.req_addr0   = '0;
        bus.req_addr1   = '0;
        bus.req_wdata0  = '0;
        bus.req_wdata1  = '0;
        bus.mem_rd_data = '0;
    endtask

    // Leaves the bench just after a rising edge with the DUT idle and out of reset.
    task automatic applyReset();
        idleInputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetModel();
        reset = 1'b1;
    endtask

    // One full transaction from a vector: accept, strobe, response.
    task automatic applyStimulus(input vec_t v, input int idx);
        bus.req_valid  = v.valid;
        bus.req_we0    = v.we0;
        bus.req_addr0  = v.addr0;
        bus.req_wdata0 = v.wdata0;
        bus.req_we1    = v.we1;
        bus.req_addr1  = v.addr1;
        bus.req_wdata1 = v.wdata1;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_ready", idx), bus.req_ready, v.expReady);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_mem_rd", idx),      bus.mem_rd,      v.expRd);
        checkOutput($sformatf("vec%0d_mem_wr", idx),      bus.mem_wr,      v.expWr);
        checkOutput($sformatf("vec%0d_mem_addr", idx),    bus.mem_addr,    v.expAddr);
        checkOutput($sformatf("vec%0d_mem_wr_data", idx), bus.mem_wr_data, v.expWdata);
        checkOutput($sformatf("vec%0d_rsp_early", idx),   bus.rsp_valid,   2'b00);
        @(posedge clk);
        #1;
        bus.mem_rd_data = v.rdData;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_rsp_valid", idx),   bus.rsp_valid,   v.expRsp);
        checkOutput($sformatf("vec%0d_rsp_rdata", idx),   bus.rsp_rdata,   v.expRdata);
        checkOutput($sformatf("vec%0d_strobe_off", idx),  {bus.mem_rd, bus.mem_wr}, 2'b00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vecs[5];
        int         expSeq[10];
        logic [1:0] g;
        bit         found;

        vecs[0] = '{2'b01, 1'b0, 9'h010, 32'h0, 1'b0, 9'h000, 32'h0, 32'hDEADBEEF,
                    2'b01, 1'b1, 1'b0, 9'h010, 32'h0, 2'b01, 32'hDEADBEEF};
        vecs[1] = '{2'b10, 1'b0, 9'h000, 32'h0, 1'b1, 9'h1FF, 32'h12345678, 32'h0BADF00D,
                    2'b10, 1'b0, 1'b1, 9'h1FF, 32'h12345678, 2'b10, 32'h0};
        vecs[2] = '{2'b11, 1'b1, 9'h0AA, 32'hA5A5A5A5, 1'b0, 9'h055, 32'h11111111, 32'h77777777,
                    2'b01, 1'b0, 1'b1, 9'h0AA, 32'hA5A5A5A5, 2'b01, 32'h0};
        vecs[3] = '{2'b10, 1'b0, 9'h000, 32'h0, 1'b0, 9'h000, 32'h0, 32'hCAFEF00D,
                    2'b10, 1'b1, 1'b0, 9'h000, 32'h0, 2'b10, 32'hCAFEF00D};
        vecs[4] = '{2'b11, 1'b0, 9'h123, 32'h0, 1'b1, 9'h100, 32'hFFFFFFFF, 32'h13579BDF,
                    2'b01, 1'b1, 1'b0, 9'h123, 32'h0, 2'b01, 32'h13579BDF};
        expSeq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset held with both ports asking: everything quiet.
        idleInputs();
        reset = 1'b0;
        bus.req_valid   = 2'b11;
        bus.req_addr0   = 9'h0F0;
        bus.req_addr1   = 9'h00F;
        bus.req_wdata0  = 32'h55AA55AA;
        bus.req_wdata1  = 32'hAA55AA55;
        bus.mem_rd_data = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready",   bus.req_ready,   2'b00);
        checkOutput("rst_rsp_valid",   bus.rsp_valid,   2'b00);
        checkOutput("rst_rsp_rdata",   bus.rsp_rdata,   32'h0);
        checkOutput("rst_mem_wr",      bus.mem_wr,      1'b0);
        checkOutput("rst_mem_rd",      bus.mem_rd,      1'b0);
        checkOutput("rst_mem_addr",    bus.mem_addr,    9'h0);
        checkOutput("rst_mem_wr_data", bus.mem_wr_data, 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("rel_req_ready", bus.req_ready, 2'b01);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("rel_mem_rd",   bus.mem_rd,   1'b1);
        checkOutput("rel_mem_addr", bus.mem_addr, 9'h0F0);

        // Table of single transactions starting from a clean starvation count.
        applyReset();
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        // Both ports hammering: port 1 gets every fifth grant.
        applyReset();
        bus.req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            found = 1'b0;
            for (int t = 0; t < 6 && !found; t++) begin
                @(negedge clk);
                if (bus.req_ready != 2'b00) begin
                    found = 1'b1;
                    checkOutput($sformatf("starve_grant%0d", k), bus.req_ready,
                                expSeq[k] != 0 ? 2'b10 : 2'b01);
                end
                @(posedge clk);
                #1;
            end
            if (!found) begin
                checks++;
                failures++;
                $display("[TB] FAIL starve_timeout%0d: got no grant, expected one within 6 cycles", k);
            end
        end

        // Port 1 alone is served at once; afterwards port 0 wins a tie.
        applyReset();
        bus.req_valid = 2'b10;
        @(negedge clk);
        checkOutput("cont_p1_alone", bus.req_ready, 2'b10);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        @(negedge clk);
        checkOutput("cont_busy_access", bus.req_ready, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("cont_busy_resp", bus.req_ready, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("cont_p0_wins", bus.req_ready, 2'b01);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;

        // Reset during the strobe cycle of a load kills it without a response.
        applyReset();
        bus.req_valid = 2'b01;
        bus.req_addr0 = 9'h033;
        @(negedge clk);
        checkOutput("midrst_accept", bus.req_ready, 2'b01);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("midrst_mem_rd_before", bus.mem_rd, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_mem_rd_after", bus.mem_rd,   1'b0);
        checkOutput("midrst_mem_addr",     bus.mem_addr, 9'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst_no_rsp%0d", t), bus.rsp_valid, 2'b00);
            checkOutput($sformatf("midrst_no_strobe%0d", t), {bus.mem_rd, bus.mem_wr}, 2'b00);
            @(posedge clk);
            #1;
        end

        // Random traffic against the reference model.
        applyReset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checkAgainstModel();
            @(posedge clk);
            modelClock(g);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (g[p] || !bus.req_valid[p]) begin
                    bus.req_valid[p] = ($urandom_range(0, 1) == 1);
                    if (p == 0) begin
                        bus.req_we0    = 1'($urandom_range(0, 1));
                        bus.req_addr0  = 9'($urandom);
                        bus.req_wdata0 = $urandom;
                    end else begin
                        bus.req_we1    = 1'($urandom_range(0, 1));
                        bus.req_addr1  = 9'($urandom);
                        bus.req_wdata1 = $urandom;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    bus.req_valid[p] = 1'b0;
                end
            end
            bus.mem_rd_data = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected it before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
